// File: rtl/pe_mvm_seq.sv
// Sequential matrix-vector PE: NOUT signed Q-format dot products of a latched NDATA-word vector
// against a locally stored weight matrix, one column per cycle, with accumulate mode and saturation.

module pe_mvm_lane #(
    parameter int WIDTH = 16,
    parameter int NDATA = 16,
    parameter int FRAC  = 8,
    parameter int CW    = $clog2(NDATA),
    parameter int AW    = 2*WIDTH + $clog2(NDATA) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce,
    input  logic                    wr,
    input  logic [CW-1:0]           waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    load,
    input  logic                    accum,
    input  logic                    mac,
    input  logic [CW-1:0]           idx,
    input  logic [WIDTH-1:0]        d,
    input  logic                    upd,
    output logic [WIDTH-1:0]        q
);
    localparam logic signed [AW-1:0] QMAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] QMIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]          w [NDATA];
    logic signed [AW-1:0]      acc;
    logic signed [AW-1:0]      shr;
    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]          wsel;

    // Operands widened to the full product width so the multiply is exact.
    always_comb begin
        wsel = w[idx];
        prod = $signed({{WIDTH{d[WIDTH-1]}}, d}) * $signed({{WIDTH{wsel[WIDTH-1]}}, wsel});
        shr  = acc >>> FRAC;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NDATA; i++) w[i] <= '0;
            acc <= '0;
            q   <= '0;
        end else if (ce) begin
            if (wr) w[waddr] <= wdata;
            if (load)
                acc <= accum ? ($signed({{(AW-WIDTH){q[WIDTH-1]}}, q}) <<< FRAC) : '0;
            else if (mac)
                acc <= acc + $signed({{(AW-2*WIDTH){prod[2*WIDTH-1]}}, prod});
            if (upd) begin
                if (shr > QMAX)      q <= {1'b0, {(WIDTH-1){1'b1}}};
                else if (shr < QMIN) q <= {1'b1, {(WIDTH-1){1'b0}}};
                else                 q <= shr[WIDTH-1:0];
            end
        end
    end
endmodule

module pe_mvm_seq #(
    parameter int WIDTH = 16,
    parameter int NDATA = 16,
    parameter int NOUT  = 4,
    parameter int FRAC  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic [1:0]               mode,
    input  logic                     start,
    input  logic [WIDTH*NDATA-1:0]   D,
    input  logic                     w_we,
    input  logic [$clog2(NDATA)-1:0] w_addr,
    input  logic [WIDTH*NOUT-1:0]    w_in,
    output logic [WIDTH*NOUT-1:0]    Q,
    output logic                     valid,
    output logic                     busy
);
    localparam int CW = $clog2(NDATA);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                       state;
    logic [CW-1:0]                count;
    logic [NDATA-1:0][WIDTH-1:0]  dlat;
    logic [NOUT-1:0][WIDTH-1:0]   qv;
    logic [NOUT-1:0][WIDTH-1:0]   wv;
    logic                         idle, go, wr;

    // Start and write are mutually exclusive by mode, and both only act in IDLE.
    assign idle = (state == IDLE);
    assign go   = idle && start && (mode == 2'b01 || mode == 2'b10);
    assign wr   = idle && w_we && (mode == 2'b00) && (32'(w_addr) < NDATA);
    assign wv   = w_in;
    assign Q    = qv;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            dlat  <= '0;
            valid <= 1'b0;
            busy  <= 1'b0;
        end else if (ce) begin
            valid <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    dlat  <= D;
                    count <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    count <= count + 1'b1;
                    if (count == CW'(NDATA-1)) state <= DONE;
                end
                DONE: begin
                    valid <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar o = 0; o < NOUT; o++) begin : g_lane
        pe_mvm_lane #(.WIDTH(WIDTH), .NDATA(NDATA), .FRAC(FRAC)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .ce    (ce),
            .wr    (wr),
            .waddr (w_addr),
            .wdata (wv[o]),
            .load  (go),
            .accum (mode[1]),
            .mac   (state == RUN),
            .idx   (count),
            .d     (dlat[count]),
            .upd   (state == DONE),
            .q     (qv[o])
        );
    end
endmodule

// File: tb/tb_pe_mvm_seq.sv
// Randomized self-checking bench for pe_mvm_seq against an integer matrix-vector reference model.

module tb_pe_mvm_seq;
    localparam int WIDTH = 16;
    localparam int NDATA = 16;
    localparam int NOUT  = 4;
    localparam int FRAC  = 8;
    localparam int CW    = $clog2(NDATA);

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   ce = 1'b1;
    logic [1:0]             mode = 2'b11;
    logic                   start = 1'b0;
    logic [WIDTH*NDATA-1:0] D = '0;
    logic                   w_we = 1'b0;
    logic [CW-1:0]          w_addr = '0;
    logic [WIDTH*NOUT-1:0]  w_in = '0;
    logic [WIDTH*NOUT-1:0]  Q;
    logic                   valid;
    logic                   busy;

    int checks = 0;
    int failures = 0;

    int wm [NOUT][NDATA];
    int qm [NOUT];
    int dm [NDATA];

    pe_mvm_seq #(.WIDTH(WIDTH), .NDATA(NDATA), .NOUT(NOUT), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .ce(ce), .mode(mode), .start(start), .D(D),
        .w_we(w_we), .w_addr(w_addr), .w_in(w_in), .Q(Q), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [WIDTH-1:0] v, input bit rnd);
        logic [WIDTH-1:0] x;
        for (int i = 0; i < NDATA; i++) begin
            x = rnd ? WIDTH'($urandom) : v;
            D[WIDTH*i +: WIDTH] = x;
            dm[i] = int'($signed(x));
        end
    endtask

    task automatic write_col(input int addr, input logic [WIDTH*NOUT-1:0] lanes);
        logic [WIDTH-1:0] x;
        mode = 2'b00; w_we = 1'b1; w_addr = CW'(addr); w_in = lanes;
        tick();
        w_we = 1'b0;
        for (int o = 0; o < NOUT; o++) begin
            x = lanes[WIDTH*o +: WIDTH];
            wm[o][addr] = int'($signed(x));
        end
    endtask

    task automatic load_all(input logic [WIDTH*NOUT-1:0] lanes);
        for (int i = 0; i < NDATA; i++) write_col(i, lanes);
    endtask

    function automatic logic [WIDTH*NOUT-1:0] splat(input logic [WIDTH-1:0] v);
        logic [WIDTH*NOUT-1:0] r;
        for (int o = 0; o < NOUT; o++) r[WIDTH*o +: WIDTH] = v;
        return r;
    endfunction

    // Runs one job: optional 5-cycle ce stall, optional disturbance while busy,
    // optional ce hold after valid to check that valid and Q freeze.
    task automatic run_job(input logic [1:0] md, input int stall_at, input bit disturb, input bit hold);
        longint acc;
        int     qn [NOUT];
        int     lat;
        bit     seen;
        logic [WIDTH-1:0] got, expv;
        logic [WIDTH*NOUT-1:0] qsnap;
        for (int o = 0; o < NOUT; o++) begin
            acc = (md == 2'b10) ? longint'(qm[o]) * (longint'(1) << FRAC) : 64'sd0;
            for (int i = 0; i < NDATA; i++) acc += longint'(dm[i]) * longint'(wm[o][i]);
            acc = acc >>> FRAC;
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
            qn[o] = int'(acc);
        end
        mode = md; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b want=1", busy); end
        seen = 0; lat = 0;
        for (int k = 1; k <= 200 && !seen; k++) begin
            if (stall_at > 0 && k == stall_at) ce = 1'b0;
            if (stall_at > 0 && k == stall_at + 5) ce = 1'b1;
            if (disturb) begin
                start = 1'($urandom); w_we = 1'($urandom); mode = 2'($urandom);
                w_addr = CW'($urandom); w_in = {$urandom, $urandom};
                D = {NDATA/2{$urandom}};
            end
            tick();
            if (valid === 1'b1) begin seen = 1; lat = k; end
        end
        start = 1'b0; w_we = 1'b0; mode = md; ce = 1'b1;
        for (int i = 0; i < NDATA; i++) D[WIDTH*i +: WIDTH] = WIDTH'(dm[i]);
        checks++;
        if (!seen) begin
            failures++; $display("FAIL valid_timeout got=none want=%0d", NDATA + 1);
        end else if (lat != NDATA + 1 + (stall_at > 0 ? 5 : 0)) begin
            failures++; $display("FAIL latency got=%0d want=%0d", lat, NDATA + 1 + (stall_at > 0 ? 5 : 0));
        end
        for (int o = 0; o < NOUT; o++) begin
            qm[o] = qn[o];
            got = Q[WIDTH*o +: WIDTH]; expv = WIDTH'(qn[o]);
            checks++;
            if (got !== expv) begin failures++; $display("FAIL q_lane%0d got=%h want=%h", o, got, expv); end
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL busy_at_valid got=%b want=0", busy); end
        if (hold) begin
            qsnap = Q; ce = 1'b0;
            repeat (3) tick();
            checks++;
            if (valid !== 1'b1 || Q !== qsnap) begin
                failures++; $display("FAIL ce_hold valid=%b want=1 q=%h want=%h", valid, Q, qsnap);
            end
            ce = 1'b1;
        end
        tick();
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL valid_pulse got=%b want=0", valid); end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int o = 0; o < NOUT; o++) begin
            qm[o] = 0;
            for (int i = 0; i < NDATA; i++) wm[o][i] = 0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (Q !== '0 || valid !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL reset_state q=%h valid=%b busy=%b want=0/0/0", Q, valid, busy);
        end
        set_d('0, 1);
        run_job(2'b01, 0, 0, 0);
    endtask

    task automatic test_basic();
        load_all(splat(16'h0100));
        set_d(16'h0100, 0);
        run_job(2'b01, 0, 0, 0);
        checks++;
        if (Q !== splat(16'h1000)) begin failures++; $display("FAIL case1 got=%h want=%h", Q, splat(16'h1000)); end
        run_job(2'b10, 0, 0, 0);
        checks++;
        if (Q !== splat(16'h2000)) begin failures++; $display("FAIL case2_acc got=%h want=%h", Q, splat(16'h2000)); end
        load_all({16'h0100, 16'hFF00, 16'h0100, 16'h0100});
        run_job(2'b01, 0, 0, 0);
        checks++;
        if (Q !== {16'h1000, 16'hF000, 16'h1000, 16'h1000}) begin
            failures++; $display("FAIL case2_lane2 got=%h want=%h", Q, {16'h1000, 16'hF000, 16'h1000, 16'h1000});
        end
    endtask

    task automatic test_saturation();
        set_d(16'h0B2A, 0);
        load_all(splat(16'h2F04));
        run_job(2'b01, 0, 0, 0);
        checks++;
        if (Q !== splat(16'h7FFF)) begin failures++; $display("FAIL sat_pos got=%h want=%h", Q, splat(16'h7FFF)); end
        load_all(splat(16'hD0FC));
        run_job(2'b01, 0, 0, 0);
        checks++;
        if (Q !== splat(16'h8000)) begin failures++; $display("FAIL sat_neg got=%h want=%h", Q, splat(16'h8000)); end
    endtask

    task automatic test_ce_stall();
        load_all(splat(16'h0100));
        set_d(16'h0100, 0);
        run_job(2'b01, 4, 0, 1);
    endtask

    task automatic test_busy_ignore();
        set_d('0, 1);
        for (int i = 0; i < NDATA; i++) write_col(i, {$urandom, $urandom});
        run_job(2'b10, 0, 1, 0);
        // A follow-up job confirms the weights were not touched by the disturbance.
        set_d('0, 1);
        run_job(2'b01, 0, 0, 0);
    endtask

    task automatic test_noop();
        logic [WIDTH*NOUT-1:0] qsnap;
        qsnap = Q;
        mode = 2'b11; start = 1'b1; w_we = 1'b1; w_addr = 3; w_in = {$urandom, $urandom};
        repeat (2) tick();
        mode = 2'b00; w_we = 1'b0;
        repeat (2) tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || Q !== qsnap) begin
            failures++; $display("FAIL noop busy=%b valid=%b q=%h want=0/0/%h", busy, valid, Q, qsnap);
        end
        ce = 1'b0; mode = 2'b00; w_we = 1'b1; w_addr = 5; w_in = {$urandom, $urandom};
        tick();
        w_we = 1'b0; mode = 2'b01; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL ce_lock_start got=%b want=0", busy); end
        ce = 1'b1;
        w_we = 1'b1; w_in = {$urandom, $urandom};
        set_d('0, 1);
        run_job(2'b01, 0, 0, 0);
        w_we = 1'b0;
        set_d('0, 1);
        run_job(2'b01, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int j = 0; j < 6; j++) begin
            for (int n = 0; n < 5; n++) write_col(int'($urandom_range(NDATA - 1)), {$urandom, $urandom});
            set_d('0, 1);
            run_job(($urandom_range(1) != 0) ? 2'b10 : 2'b01, 0, 0, 0);
        end
    endtask

    task automatic test_rst_mid_run();
        set_d('0, 1);
        mode = 2'b01; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (Q !== '0 || busy !== 1'b0 || valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid_run q=%h busy=%b valid=%b want=0/0/0", Q, busy, valid);
        end
        rst = 1'b0;
        do_reset();
        set_d('0, 1);
        run_job(2'b01, 0, 0, 0);
    endtask

    initial begin
        tick();
        test_reset();
        test_basic();
        test_saturation();
        test_ce_stall();
        test_busy_ignore();
        test_noop();
        test_random();
        test_rst_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
